// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// Defines the packed-word FIFO entry layout.
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int CNT_W          = 3;
  localparam int ENTRY_W        = 36;

  localparam int DATA_LSB  = 0;
  localparam int BYTES_LSB = 32;
  localparam int ERR_BIT   = 35;

  function automatic logic [ENTRY_W-1:0] make_entry(
    input logic              err,
    input logic [CNT_W-1:0]  nbytes,
    input logic [WORD_W-1:0] data
  );
    logic [ENTRY_W-1:0] e;
    e                      = '0;
    e[ERR_BIT]             = err;
    e[BYTES_LSB +: CNT_W]  = nbytes;
    e[DATA_LSB +: WORD_W]  = data;
    return e;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// A pop frees the slot for a same-cycle push even when full.
module rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over push and pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; reset zeroes it so the head reads 0 after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs UART bytes little-endian into 32-bit words.
// Flushes partial words after an idle gap; buffers in a FIFO.
module rx_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_error,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles,
  input  logic                   clear,
  output logic                   word_valid,
  output logic [31:0]            word_data,
  output logic [2:0]             word_bytes,
  output logic                   word_error,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  logic [1:0]           idx, idx_nx;
  logic [WORD_W-1:0]    acc, acc_nx, acc_ins;
  logic                 err, err_nx;
  logic [TIMEOUT_W-1:0] cnt, cnt_nx;
  logic                 ovf_nx;

  logic                 word_done;
  logic                 timeout_hit;
  logic                 push;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head;
  logic                 full;
  logic                 empty;

  assign word_done = byte_valid && (idx == 2'd3);

  assign timeout_hit = !byte_valid
                    && (idx != 2'd0)
                    && (timeout_cycles != '0)
                    && (cnt == timeout_cycles - TIMEOUT_W'(1));

  assign push = !clear && (word_done || timeout_hit);

  // Current accumulator with the incoming byte placed in lane idx
  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (idx == 2'(k)) acc_ins[8*k +: 8] = byte_data;
    end
  end

  // Entry to push: full word with the new byte, or flushed partial
  always_comb begin
    push_entry = make_entry(err, {1'b0, idx}, acc);
    if (word_done) begin
      push_entry = make_entry(err | byte_error, 3'd4, acc_ins);
    end
  end

  // Packer, idle counter and overflow next state
  always_comb begin
    idx_nx = idx;
    acc_nx = acc;
    err_nx = err;
    cnt_nx = cnt;
    ovf_nx = overflow;
    if (clear) begin
      idx_nx = '0;
      acc_nx = '0;
      err_nx = 1'b0;
      cnt_nx = '0;
      ovf_nx = 1'b0;
    end else begin
      if (push && full && !word_ready) ovf_nx = 1'b1;
      if (byte_valid) begin
        cnt_nx = '0;
        if (word_done) begin
          idx_nx = '0;
          acc_nx = '0;
          err_nx = 1'b0;
        end else begin
          idx_nx = idx + 2'd1;
          acc_nx = acc_ins;
          err_nx = err | byte_error;
        end
      end else if (timeout_hit) begin
        idx_nx = '0;
        acc_nx = '0;
        err_nx = 1'b0;
        cnt_nx = '0;
      end else if (idx == 2'd0) begin
        cnt_nx = '0;
      end else if (timeout_cycles != '0 && cnt != '1) begin
        // Saturate so a lowered limit cannot be hit by wrap-around
        cnt_nx = cnt + TIMEOUT_W'(1);
      end
    end
  end

  // Packer and overflow state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      acc      <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      idx      <= idx_nx;
      acc      <= acc_nx;
      err      <= err_nx;
      cnt      <= cnt_nx;
      overflow <= ovf_nx;
    end
  end

  rx_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (word_ready),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign word_valid = ~empty;
  assign word_data  = head[DATA_LSB +: WORD_W];
  assign word_bytes = head[BYTES_LSB +: CNT_W];
  assign word_error = head[ERR_BIT];

endmodule

// File: tb/tb_rx_word_packer.sv
// Self-checking bench for rx_word_packer.
// Directed steps then random traffic against a queue model.
module tb_rx_word_packer;

  localparam int DEPTH = 8;
  localparam int TW    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_error;
  logic [TW-1:0] timeout_cycles;
  logic        clear;
  logic        word_valid;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_error;
  logic        word_ready;
  logic [3:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [35:0] mq[$];
  logic [7:0]  pend[$];
  logic        perr;
  int          idle;
  logic        movf;

  always #5 clock = ~clock;

  rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
    .clock          (clock),
    .reset          (reset),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_error     (byte_error),
    .timeout_cycles (timeout_cycles),
    .clear          (clear),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_bytes     (word_bytes),
    .word_error     (word_error),
    .word_ready     (word_ready),
    .level          (level),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    pend.delete();
    perr = 1'b0;
    idle = 0;
    movf = 1'b0;
  endfunction

  // One clock of the reference behaviour, from the current inputs
  function automatic void model_step();
    logic [35:0] w;
    bit have;
    bit pop;
    if (clear) begin
      model_reset();
      return;
    end
    pop  = word_ready && (mq.size() > 0);
    have = 0;
    w    = '0;
    if (byte_valid) begin
      pend.push_back(byte_data);
      perr = perr | byte_error;
      idle = 0;
      if (pend.size() == 4) have = 1;
    end else if (pend.size() > 0 && timeout_cycles != 0) begin
      idle++;
      if (idle == int'(timeout_cycles)) have = 1;
    end
    if (have) begin
      foreach (pend[k]) w[8*k +: 8] = pend[k];
      w[34:32] = 3'(pend.size());
      w[35]    = perr;
      pend.delete();
      perr = 1'b0;
      idle = 0;
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else movf = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    chk("word_valid", 36'(word_valid), 36'(mq.size() != 0));
    chk("level", 36'(level), 36'(mq.size()));
    chk("overflow", 36'(overflow), 36'(movf));
    if (mq.size() > 0)
      chk("head", {word_error, word_bytes, word_data}, mq[0]);
  endtask

  task automatic step(input logic bv, input logic [7:0] bd,
                      input logic be, input logic rdy, input logic clr);
    byte_valid = bv;
    byte_data  = bd;
    byte_error = be;
    word_ready = rdy;
    clear      = clr;
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b, input logic e, input logic rdy);
    step(1'b1, b, e, rdy, 1'b0);
  endtask

  task automatic wait_idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset          = 1'b0;
    byte_valid     = 1'b0;
    byte_data      = 8'h00;
    byte_error     = 1'b0;
    timeout_cycles = '0;
    clear          = 1'b0;
    word_ready     = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 36'(word_valid), 36'd0);
    chk("rst_head", {word_error, word_bytes, word_data}, 36'd0);
    chk("rst_level", 36'(level), 36'd0);
    chk("rst_ovf", 36'(overflow), 36'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic word, visible the cycle after the 4th byte
    send(8'h11, 0, 1);
    send(8'h22, 0, 1);
    send(8'h33, 0, 1);
    send(8'h44, 0, 0);
    chk("word1", {word_error, word_bytes, word_data},
        {1'b0, 3'd4, 32'h44332211});
    wait_idle(2, 1);

    // Idle flush after 20 cycles
    timeout_cycles = 16'd20;
    send(8'hAA, 0, 0);
    send(8'hBB, 0, 0);
    wait_idle(19, 0);
    chk("flush_early", 36'(level), 36'd0);
    wait_idle(1, 0);
    chk("flush_word", {word_error, word_bytes, word_data},
        {1'b0, 3'd2, 32'h0000BBAA});
    wait_idle(3, 1);

    // No flush when disabled
    timeout_cycles = '0;
    send(8'h01, 0, 1);
    send(8'h02, 0, 1);
    wait_idle(100, 1);
    chk("no_flush", 36'(level), 36'd0);
    send(8'h03, 0, 1);
    send(8'h04, 0, 0);
    wait_idle(2, 1);

    // Error on the 3rd byte, then a clean word
    send(8'hC0, 0, 0);
    send(8'hC1, 0, 0);
    send(8'hC2, 1, 0);
    send(8'hC3, 0, 0);
    chk("err_word", 36'(word_error), 36'd1);
    wait_idle(1, 1);
    send(8'hD0, 0, 0);
    send(8'hD1, 0, 0);
    send(8'hD2, 0, 0);
    send(8'hD3, 0, 0);
    chk("clean_word", 36'(word_error), 36'd0);
    wait_idle(2, 1);

    // Overflow: 9 words into 8 slots, then drain
    do_clear();
    for (int i = 0; i < 36; i++) send(8'(i * 7 + 3), 0, 0);
    chk("ovf_level", 36'(level), 36'd8);
    chk("ovf_flag", 36'(overflow), 36'd1);
    wait_idle(10, 1);
    chk("drained", 36'(level), 36'd0);

    // Full FIFO with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 35; i++) send(8'(i + 8'h40), 0, 0);
    send(8'h99, 0, 1);
    chk("pp_level", 36'(level), 36'd8);
    chk("pp_ovf", 36'(overflow), 36'd0);
    wait_idle(10, 1);

    // Clear with level 3 and a 2-byte partial word
    for (int i = 0; i < 14; i++) send(8'(i + 8'h60), 0, 0);
    chk("pre_clear", 36'(level), 36'd3);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clr_level", 36'(level), 36'd0);
    chk("clr_valid", 36'(word_valid), 36'd0);
    send(8'h5A, 0, 0);
    send(8'h5B, 0, 0);
    send(8'h5C, 0, 0);
    send(8'h5D, 0, 0);
    chk("post_clear", {word_error, word_bytes, word_data},
        {1'b0, 3'd4, 32'h5D5C5B5A});
    wait_idle(2, 1);

    // Asynchronous reset mid-word
    send(8'h71, 0, 0);
    send(8'h72, 0, 0);
    send(8'h73, 0, 0);
    send(8'h74, 0, 0);
    send(8'h75, 0, 0);
    byte_valid = 1'b0;
    word_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 36'(word_valid), 36'd0);
    chk("arst_head", {word_error, word_bytes, word_data}, 36'd0);
    chk("arst_level", 36'(level), 36'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send(8'h81, 0, 0);
    send(8'h82, 0, 0);
    send(8'h83, 0, 0);
    send(8'h84, 0, 0);
    chk("arst_word", {word_error, word_bytes, word_data},
        {1'b0, 3'd4, 32'h84838281});
    wait_idle(2, 1);

    // Random traffic with a short idle timeout
    do_clear();
    timeout_cycles = 16'd7;
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = ((i % 400) < 150) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0,
           rdy, $urandom_range(0, 299) == 0);
    end
    wait_idle(20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
